// File: rtl/smc_serial_calc_if.sv
// Streaming bus for smc_serial_calc: one MOSFET per in_valid beat in, one
// registered 10-bit result strobe out.
interface smc_serial_calc_if;
    logic       in_valid;
    logic [1:0] mode;
    logic [2:0] W;
    logic [2:0] V_GS;
    logic [2:0] V_DS;
    logic       out_valid;
    logic [9:0] out_n;

    modport master (
        output in_valid, mode, W, V_GS, V_DS,
        input  out_valid, out_n
    );

    modport slave (
        input  in_valid, mode, W, V_GS, V_DS,
        output out_valid, out_n
    );
endinterface

// File: rtl/smc_serial_calc.sv
// Serial MOSFET calculator: evaluates six devices on arrival, keeps them sorted,
// and emits a weighted result. Define SMC_DIV_ROUND_EN for round-to-nearest division.
module smc_serial_calc (
    input  logic             clk,
    input  logic             rst_n,
    smc_serial_calc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
    typedef logic [6:0] val_t;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [1:0] mode_q;
    val_t       s_q [6];
    logic [9:0] result_q;
    logic       out_valid_q;
    logic [9:0] out_n_q;

    logic [1:0] cur_mode;
    logic [2:0] n_fill;
    logic [8:0] w9, vds9, vov9;
    logic [8:0] num_d;
    val_t       dev_d;
    val_t       s_eff [6];
    logic [2:0] pos_d;
    val_t       ins_d [6];
    logic [9:0] e0, e1, e2;
    logic [9:0] result_d;

    // Beat 0 arrives in IDLE or OUT, where the array is logically empty and
    // the mode comes straight off the bus rather than from the latch.
    assign cur_mode = (state_q == LOAD) ? mode_q : bus.mode;
    assign n_fill   = (state_q == LOAD) ? cnt_q : 3'd0;

    assign w9   = {6'd0, bus.W};
    assign vds9 = {6'd0, bus.V_DS};
    assign vov9 = {6'd0, bus.V_GS} - 9'd1;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        num_d = '0;
        if (bus.V_GS > 3'd1) begin
            if (vov9 > vds9) begin
                num_d = cur_mode[0] ? w9 * vds9 * (9'd2 * vov9 - vds9)
                                    : 9'd2 * w9 * vds9;
            end else begin
                num_d = cur_mode[0] ? w9 * vov9 * vov9
                                    : 9'd2 * w9 * vov9;
            end
        end
    end

`ifdef SMC_DIV_ROUND_EN
    assign dev_d = val_t'((num_d + 9'd1) / 9'd3);
`else
    assign dev_d = val_t'(num_d / 9'd3);
`endif

    always_comb begin
        for (int j = 0; j < 6; j++) begin
            s_eff[j] = (3'(j) < n_fill) ? s_q[j] : '0;
        end
    end

    // Ties go below existing entries: count every filled slot that is >= the new value.
    always_comb begin
        pos_d = '0;
        for (int j = 0; j < 6; j++) begin
            if ((3'(j) < n_fill) && (s_q[j] >= dev_d)) begin
                pos_d = pos_d + 3'd1;
            end
        end
        ins_d[0] = (pos_d == 3'd0) ? dev_d : s_eff[0];
        for (int i = 1; i < 6; i++) begin
            if (3'(i) < pos_d) begin
                ins_d[i] = s_eff[i];
            end else if (3'(i) == pos_d) begin
                ins_d[i] = dev_d;
            end else begin
                ins_d[i] = s_eff[i-1];
            end
        end
    end

    always_comb begin
        e0 = {3'd0, (mode_q[1] ? s_q[0] : s_q[3])};
        e1 = {3'd0, (mode_q[1] ? s_q[1] : s_q[4])};
        e2 = {3'd0, (mode_q[1] ? s_q[2] : s_q[5])};
        if (mode_q[0]) begin
`ifdef SMC_DIV_ROUND_EN
            result_d = (10'd3 * e0 + 10'd4 * e1 + 10'd5 * e2 + 10'd6) / 10'd12;
`else
            result_d = (10'd3 * e0 + 10'd4 * e1 + 10'd5 * e2) / 10'd12;
`endif
        end else begin
            result_d = e0 + e1 + e2;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= '0;
            // NOTE: the sorted array is reset like any other state; abort and reset must leave it zero.
            s_q         <= '{default: '0};
            result_q    <= '0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
        end else begin
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mode_q  <= bus.mode;
                        s_q     <= ins_d;
                        cnt_q   <= 3'd1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        s_q   <= ins_d;
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd5) begin
                            state_q <= CALC;
                        end
                    end else begin
                        s_q     <= '{default: '0};
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    result_q <= result_d;
                    cnt_q    <= '0;
                    state_q  <= OUT;
                end
                OUT: begin
                    out_valid_q <= 1'b1;
                    out_n_q     <= result_q;
                    if (bus.in_valid) begin
                        mode_q  <= bus.mode;
                        s_q     <= ins_d;
                        cnt_q   <= 3'd1;
                        state_q <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_n     = out_n_q;
endmodule

// File: tb/tb_smc_serial_calc.sv
// Randomized bench for smc_serial_calc against a sort-and-sum reference model,
// plus directed jobs with hand-computed results.
module tb_smc_serial_calc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    smc_serial_calc_if bus ();
    smc_serial_calc dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef SMC_DIV_ROUND_EN
    localparam int GM_SMALL = 4;
    localparam int GM_LARGE = 10;
    localparam int SAT_EXP  = 3;
`else
    localparam int GM_SMALL = 3;
    localparam int GM_LARGE = 9;
    localparam int SAT_EXP  = 2;
`endif

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   jw[6];
    int   jg[6];
    int   jd[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int dev_val(input bit cur, input int w, input int vgs, input int vds);
        int vov;
        int num;
        if (vgs <= 1) return 0;
        vov = vgs - 1;
        if (vov > vds) num = cur ? w * vds * (2 * vov - vds) : 2 * w * vds;
        else           num = cur ? w * vov * vov : 2 * w * vov;
`ifdef SMC_DIV_ROUND_EN
        return (num + 1) / 3;
`else
        return num / 3;
`endif
    endfunction

    function automatic int job_model(input logic [1:0] m);
        int v[6];
        int t;
        int n0, n1, n2;
        for (int b = 0; b < 6; b++) v[b] = dev_val(m[0], jw[b], jg[b], jd[b]);
        for (int a = 0; a < 5; a++)
            for (int b = 0; b < 5 - a; b++)
                if (v[b] < v[b+1]) begin
                    t = v[b]; v[b] = v[b+1]; v[b+1] = t;
                end
        if (m[1]) begin n0 = v[0]; n1 = v[1]; n2 = v[2]; end
        else      begin n0 = v[3]; n1 = v[4]; n2 = v[5]; end
        if (!m[0]) return n0 + n1 + n2;
`ifdef SMC_DIV_ROUND_EN
        return (3 * n0 + 4 * n1 + 5 * n2 + 6) / 12;
`else
        return (3 * n0 + 4 * n1 + 5 * n2) / 12;
`endif
    endfunction

    // Every negedge: a pulse is expected exactly where the queue says, zeros elsewhere.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("out_valid_pulse", int'(bus.out_valid), 1);
            check("out_n_result", int'(bus.out_n), exp_q[0].val);
            void'(exp_q.pop_front());
        end else begin
            check("out_valid_quiet", int'(bus.out_valid), 0);
            check("out_n_quiet", int'(bus.out_n), 0);
        end
    end

    task automatic drive_noise(input logic valid);
        bus.in_valid = valid;
        bus.mode     = 2'($urandom);
        bus.W        = 3'($urandom);
        bus.V_GS     = 3'($urandom);
        bus.V_DS     = 3'($urandom);
    endtask

    task automatic drive_beat(input int b, input logic [1:0] m);
        bus.in_valid = 1'b1;
        bus.mode     = (b == 0) ? m : 2'($urandom);
        bus.W        = 3'(jw[b]);
        bus.V_GS     = 3'(jg[b]);
        bus.V_DS     = 3'(jd[b]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_noise(1'b0);
        end
    endtask

    // Six beats, then one CALC-cycle beat (optionally with in_valid high, which must be ignored).
    task automatic send_job(input logic [1:0] m, input int lit, input bit noise);
        int   mdl;
        exp_t e;
        mdl = job_model(m);
        if (lit >= 0) check("model_pin", mdl, lit);
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            drive_beat(b, m);
            if (b == 5) begin
                e.due = cyc + 3;
                e.val = (lit >= 0) ? lit : mdl;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        drive_noise(noise);
    endtask

    task automatic abort_job(input int k);
        for (int b = 0; b < k; b++) begin
            @(negedge clk);
            drive_beat(b, 2'($urandom));
        end
        @(negedge clk);
        drive_noise(1'b0);
    endtask

    task automatic fill_all(input int w, input int vgs, input int vds);
        for (int b = 0; b < 6; b++) begin
            jw[b] = w; jg[b] = vgs; jd[b] = vds;
        end
    endtask

    task automatic fill_random();
        for (int b = 0; b < 6; b++) begin
            jw[b] = $urandom_range(0, 7);
            jg[b] = $urandom_range(0, 7);
            jd[b] = $urandom_range(0, 7);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit, %0d jobs still pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        drive_noise(1'b0);
        repeat (2) @(negedge clk);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_n", int'(bus.out_n), 0);
        rst_n = 1'b1;
        idle(2);

        // Six saturated full-size devices: every current is 84.
        fill_all(7, 7, 7);
        send_job(2'd3, 84, 1'b0);
        idle(4);

        // gm values 0,1,2,2,3,4; second burst begins in the OUT cycle.
        for (int b = 0; b < 6; b++) begin
            jw[b] = b + 1; jg[b] = 3; jd[b] = 1;
        end
        send_job(2'd0, GM_SMALL, 1'b0);
        send_job(2'd2, GM_LARGE, 1'b0);
        idle(4);

        // All devices in cutoff.
        for (int b = 0; b < 6; b++) begin
            jw[b] = $urandom_range(0, 7);
            jg[b] = $urandom_range(0, 1);
            jd[b] = $urandom_range(0, 7);
        end
        send_job(2'd3, 0, 1'b1);
        idle(3);

        // Abort after three beats, then a clean job.
        fill_all(7, 7, 7);
        abort_job(3);
        idle(10);
        send_job(2'd3, 84, 1'b0);
        idle(4);

        // Reset during beat 4, then a clean job.
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            drive_beat(b, 2'd3);
        end
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_valid", int'(bus.out_valid), 0);
        check("reset_mid_n", int'(bus.out_n), 0);
        @(negedge clk);
        drive_noise(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_job(2'd3, 84, 1'b0);
        idle(4);

        // Reset while the result pulse is on the outputs clears them at once.
        send_job(2'd3, 84, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_pulse_valid", int'(bus.out_valid), 0);
        check("reset_pulse_n", int'(bus.out_n), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Saturation with I_num = 8: floor gives 2, rounding gives 3.
        fill_all(2, 3, 3);
        send_job(2'd3, SAT_EXP, 1'b0);
        idle(3);

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                abort_job($urandom_range(1, 5));
                idle($urandom_range(1, 3));
            end else begin
                fill_random();
                send_job(2'($urandom), -1, ($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
        end
        idle(6);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
